// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the MIPS datapath.
// Decodes IR Op/Funct and steps the datapath one state per clock, driving
// ALU operation and operand selects, register/memory strobes and the PC
// source. Memory states stall on MemReady; BRANCH uses the ALU Zero flag.
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN to make TRAP a sticky state
// (held until reset); otherwise TRAP skips the instruction in one cycle.
module mc_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter logic [4:0] JAL_REG     = 5'd31
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [4:0] ALUOp,
  output logic       EXTOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  // ALU operation codes; these must match the ALU's own decode table.
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [4:0] ALU_SLLV = 5'd12;
  localparam logic [4:0] ALU_SRLV = 5'd13;
  localparam logic [4:0] ALU_SRAV = 5'd14;
  localparam logic [4:0] ALU_LUI  = 5'd15;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JR     = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // The link register is a datapath constant selected by RegDst=2; $zero
  // would silently discard the return address.
  if (JAL_REG == 5'd0) begin : g_jal_reg_check
    $error("mc_ctrl: JAL_REG must not be register 0");
  end

  // R-type Funct to ALU operation; ALU_NOP marks an unsupported Funct.
  function automatic logic [4:0] f_rtype_aluop(input logic [5:0] fn);
    case (fn)
      F_ADD, F_ADDU: f_rtype_aluop = ALU_ADD;
      F_SUB, F_SUBU: f_rtype_aluop = ALU_SUB;
      F_AND:         f_rtype_aluop = ALU_AND;
      F_OR:          f_rtype_aluop = ALU_OR;
      F_XOR:         f_rtype_aluop = ALU_XOR;
      F_NOR:         f_rtype_aluop = ALU_NOR;
      F_SLT:         f_rtype_aluop = ALU_SLT;
      F_SLTU:        f_rtype_aluop = ALU_SLTU;
      F_SLL:         f_rtype_aluop = ALU_SLL;
      F_SRL:         f_rtype_aluop = ALU_SRL;
      F_SRA:         f_rtype_aluop = ALU_SRA;
      F_SLLV:        f_rtype_aluop = ALU_SLLV;
      F_SRLV:        f_rtype_aluop = ALU_SRLV;
      F_SRAV:        f_rtype_aluop = ALU_SRAV;
      default:       f_rtype_aluop = ALU_NOP;
    endcase
  endfunction

  // Immediate-class opcode to ALU operation.
  function automatic logic [4:0] f_itype_aluop(input logic [5:0] op);
    case (op)
      OP_ADDI:  f_itype_aluop = ALU_ADD;
      OP_ANDI:  f_itype_aluop = ALU_AND;
      OP_ORI:   f_itype_aluop = ALU_OR;
      OP_XORI:  f_itype_aluop = ALU_XOR;
      OP_SLTI:  f_itype_aluop = ALU_SLT;
      OP_SLTIU: f_itype_aluop = ALU_SLTU;
      OP_LUI:   f_itype_aluop = ALU_LUI;
      default:  f_itype_aluop = ALU_NOP;
    endcase
  endfunction

  // Constant shifts take their amount from the shamt field instead of rs.
  function automatic logic f_is_shamt(input logic [5:0] fn);
    f_is_shamt = (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA);
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic       w_pcw;
  logic       w_irw;
  logic       w_mr;
  logic       w_mw;
  logic       w_rw;
  logic       w_ill;
  logic [4:0] w_r_aluop;
  logic       w_logic_imm;
  logic [4:0] r_hold_aluop;
  logic [1:0] r_hold_srca;
  logic [1:0] r_hold_srcb;
  logic       r_hold_ext;

  assign w_r_aluop   = f_rtype_aluop(Funct);
  assign w_logic_imm = (Op == OP_ANDI) || (Op == OP_ORI) || (Op == OP_XORI);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= state_t'(RESET_STATE);
    else       r_state <= w_next;
  end

  // Keep the exec-stage ALU setup so ALUWB presents the same datapath selects.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold_aluop <= ALU_NOP;
      r_hold_srca  <= 2'd0;
      r_hold_srcb  <= 2'd0;
      r_hold_ext   <= 1'b0;
    end else if (r_state == S_EXEC_R || r_state == S_EXEC_I) begin
      r_hold_aluop <= ALUOp;
      r_hold_srca  <= ALUSrcA;
      r_hold_srcb  <= ALUSrcB;
      r_hold_ext   <= EXTOp;
    end
  end

  // Next-state and per-state control decode; unlisted controls stay 0.
  always_comb begin
    w_next   = r_state;
    w_pcw    = 1'b0;
    w_irw    = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_rw     = 1'b0;
    w_ill    = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ALUOp    = ALU_NOP;
    EXTOp    = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    PCSource = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_mr    = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = ALU_ADD;
        if (MemReady) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target (PC+4 + imm<<2) is computed speculatively here.
        ALUSrcB = 2'd3;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        case (Op)
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_RTYPE:        w_next = (Funct == F_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
          OP_SLTI, OP_SLTIU, OP_LUI:
                           w_next = S_EXEC_I;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J, OP_JAL:    w_next = S_JUMP;
          default:         w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        w_next  = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mr = 1'b1;
        IorD = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        w_mw = 1'b1;
        IorD = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_rw     = 1'b1;
        MemtoReg = 2'd1;
        w_next   = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = f_is_shamt(Funct) ? 2'd2 : 2'd1;
        ALUOp   = w_r_aluop;
        w_next  = (w_r_aluop == ALU_NOP) ? S_TRAP : S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        EXTOp   = ~w_logic_imm;
        ALUOp   = f_itype_aluop(Op);
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw    = 1'b1;
        RegDst  = (Op == OP_RTYPE) ? 2'd1 : 2'd0;
        ALUSrcA = r_hold_srca;
        ALUSrcB = r_hold_srcb;
        ALUOp   = r_hold_aluop;
        EXTOp   = r_hold_ext;
        w_next  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'd1;
        ALUOp    = ALU_SUB;
        PCSource = 2'd1;
        w_pcw    = (Op == OP_BNE) ? ~Zero : Zero;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        w_pcw    = 1'b1;
        PCSource = 2'd2;
        if (Op == OP_JAL) begin
          // PC already holds PC+4 from FETCH, which is the link value.
          w_rw     = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
        w_next = S_FETCH;
      end
      S_JR: begin
        w_pcw    = 1'b1;
        PCSource = 2'd3;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        w_ill = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        w_next = S_TRAP;
`else
        w_next = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is asserted so nothing is written.
  assign PCWrite  = rstn & w_pcw;
  assign IRWrite  = rstn & w_irw;
  assign MemRead  = rstn & w_mr;
  assign MemWrite = rstn & w_mw;
  assign RegWrite = rstn & w_rw;
  assign Illegal  = rstn & w_ill;
  assign State    = r_state;

endmodule
